pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the IF/ID register hold (hazard_IF_ID) and flush controls, PC write enable, ID/EX bubble insertion and a whole-pipe freeze during multi-cycle data-memory accesses.
- Sits beside the ID stage; consumes decoded register indices from IF/ID and load/memory status from EX/MEM.

Parameters:
- REG_W, 5, register index width
- TIMEOUT, 64, max MEM_WAIT cycles before abort and error flag
- CNT_W, 16, width of saturating performance counters

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- id_rs_i  in  REG_W  rs of instruction in ID
- id_rt_i  in  REG_W  rt of instruction in ID
- id_uses_rt_i  in  1  ID instruction reads rt
- ex_mem_read_i  in  1  instruction in EX is a load
- ex_rt_i  in  REG_W  destination of the load in EX
- branch_taken_i  in  1  branch/jump resolved taken in ID
- mem_req_i  in  1  data-memory access issued from MEM this cycle
- mem_ready_i  in  1  data memory completes access
- pc_write_o  out  1  PC update enable
- hazard_IF_ID_o  out  1  hold IF/ID (1 = stall)
- flush_IF_ID_o  out  1  zero IF/ID instruction
- bubble_ID_EX_o  out  1  zero ID/EX control bits
- freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- err_o  out  1  sticky memory-timeout flag
- stall_cnt_o  out  CNT_W  saturating count of stall cycles
- flush_cnt_o  out  CNT_W  saturating count of flushes

Behaviour:
- State register: INIT, RUN, MEM_WAIT. Async reset forces INIT, wait counter 0, err_o 0, both counters 0.
- Control outputs are combinational from state and inputs (Mealy). State, wait counter, err_o and counters are registered.
- INIT (one cycle after reset release): pc_write_o=0, hazard_IF_ID_o=1, flush_IF_ID_o=1, bubble_ID_EX_o=1, freeze_o=0; next state RUN. The same values are driven while rst_i=1.
- RUN priority, first match wins:
  1. Memory wait: mem_req_i=1 and mem_ready_i=0 -> freeze_o=1, pc_write_o=0, hazard_IF_ID_o=1, flush/bubble 0; next MEM_WAIT, wait counter <= 1.
  2. Load-use: ex_mem_read_i and ex_rt_i!=0 and (ex_rt_i==id_rs_i or (id_uses_rt_i and ex_rt_i==id_rt_i)) -> pc_write_o=0, hazard_IF_ID_o=1, bubble_ID_EX_o=1, flush_IF_ID_o=0. The branch is ignored this cycle and re-evaluated next cycle.
  3. Branch taken -> flush_IF_ID_o=1, pc_write_o=1, hazard_IF_ID_o=0.
  4. Otherwise: pc_write_o=1, all others 0.
- MEM_WAIT:
  - freeze_o=1, pc_write_o=0, hazard_IF_ID_o=1, flush/bubble 0.
  - mem_ready_i=1 -> outputs still frozen this cycle; next RUN.
  - Else, wait counter reaching TIMEOUT -> err_o<=1 (sticky until reset); next RUN.
  - Else counter increments.
- Register 0 never triggers load-use.
- stall_cnt_o increments on every cycle in which pc_write_o=0 while in RUN or MEM_WAIT.
- flush_cnt_o increments on each cycle with flush_IF_ID_o=1 in RUN.
- Both counters saturate at all-ones; neither counts INIT.
- Reset asserted mid-MEM_WAIT: immediate INIT values, counter cleared.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum (INIT, RUN, MEM_WAIT)
  - REG_ZERO constant
  - default REG_W/CNT_W constants, shared with the pipeline registers
- One sub-module: sat_counter (parameter W, inc_i, count_o), instantiated twice.

Test Plan:
- Reset: rst_i=1 for 3 cycles, then release -> first cycle pc_write_o=0, flush_IF_ID_o=1; second cycle pc_write_o=1, all other controls 0, counters 0.
- Load-use: ex_mem_read_i=1, ex_rt_i=5, id_rs_i=5 -> one cycle of pc_write_o=0, hazard_IF_ID_o=1, bubble_ID_EX_o=1; stall_cnt_o=1. Repeat with ex_rt_i=0 -> no stall.
- Load-use and branch together: ex_rt_i=3, id_rt_i=3, id_uses_rt_i=1, branch_taken_i=1 -> stall only, flush_IF_ID_o=0. Next cycle with load cleared -> flush_IF_ID_o=1, flush_cnt_o=1.
- Memory wait: mem_req_i=1, mem_ready_i=0 for 4 cycles, then 1 -> freeze_o=1 for 5 cycles total, then RUN; stall_cnt_o=5.
- Timeout: TIMEOUT=8, mem_ready_i held 0 -> err_o rises after cycle 8 of MEM_WAIT and stays 1. Then rst_i pulse -> err_o=0.
- Saturation: CNT_W=4, 20 load-use stalls -> stall_cnt_o holds 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and default widths.
// Imported by the hazard controller and the pipeline registers.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   localparam int REG_W_DEF = 5;
   localparam int CNT_W_DEF = 16;
   localparam int REG_ZERO  = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter used for the stall and flush statistics.
// Holds at all-ones once reached.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] r_cnt;

   // Count one event per cycle, stopping at the top value.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= '0;
      end else if (inc_i && (r_cnt != '1)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign count_o = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// branch flushes and whole-pipe freeze while data memory is busy.
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_W   = REG_W_DEF,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             hazard_IF_ID_o,
   output logic             flush_IF_ID_o,
   output logic             bubble_ID_EX_o,
   output logic             freeze_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_wait;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              r_err;
   logic              w_err_nxt;
   logic              w_load_use;
   logic              w_pc_write;
   logic              w_hazard;
   logic              w_flush;
   logic              w_bubble;
   logic              w_freeze;
   logic              w_stall_inc;
   logic              w_flush_inc;

   // Load in EX whose destination is read by the ID instruction.
   always_comb begin
      w_load_use = ex_mem_read_i
                && (ex_rt_i != REG_W'(REG_ZERO))
                && ((ex_rt_i == id_rs_i)
                 || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
   end

   // State, wait counter and error flag registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_INIT;
         r_wait  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next-state logic and Mealy control outputs.
   always_comb begin
      w_next     = r_state;
      w_wait_nxt = r_wait;
      w_err_nxt  = r_err;
      w_pc_write = 1'b1;
      w_hazard   = 1'b0;
      w_flush    = 1'b0;
      w_bubble   = 1'b0;
      w_freeze   = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (mem_req_i && !mem_ready_i) begin
               w_freeze   = 1'b1;
               w_pc_write = 1'b0;
               w_hazard   = 1'b1;
               w_next     = ST_MEM_WAIT;
               w_wait_nxt = WAIT_W'(1);
            end else if (w_load_use) begin
               w_pc_write = 1'b0;
               w_hazard   = 1'b1;
               w_bubble   = 1'b1;
            end else if (branch_taken_i) begin
               w_flush    = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            w_freeze   = 1'b1;
            w_pc_write = 1'b0;
            w_hazard   = 1'b1;
            if (mem_ready_i) begin
               w_next = ST_RUN;
            end else if (r_wait == WAIT_W'(TIMEOUT)) begin
               w_err_nxt = 1'b1;
               w_next    = ST_RUN;
            end else begin
               w_wait_nxt = r_wait + WAIT_W'(1);
            end
         end
         default: begin
            w_pc_write = 1'b0;
            w_hazard   = 1'b1;
            w_flush    = 1'b1;
            w_bubble   = 1'b1;
            w_next     = ST_RUN;
         end
      endcase
   end

   assign w_stall_inc = !w_pc_write && (r_state != ST_INIT);
   assign w_flush_inc = w_flush && (r_state == ST_RUN);

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (w_stall_inc),
      .count_o (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (w_flush_inc),
      .count_o (flush_cnt_o)
   );

   assign pc_write_o     = w_pc_write;
   assign hazard_IF_ID_o = w_hazard;
   assign flush_IF_ID_o  = w_flush;
   assign bubble_ID_EX_o = w_bubble;
   assign freeze_o       = w_freeze;
   assign err_o          = r_err;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=8, CNT_W=4.
// Expected values are queued per step and checked at the falling edge.
module tb_pipeline_hazard_ctrl;

   localparam int RW = 5;
   localparam int CW = 4;

   // {pc_write, hazard, flush, bubble, freeze}
   localparam logic [4:0] C_INIT = 5'b01110;
   localparam logic [4:0] C_RUN  = 5'b10000;
   localparam logic [4:0] C_LU   = 5'b01010;
   localparam logic [4:0] C_BR   = 5'b10100;
   localparam logic [4:0] C_FRZ  = 5'b01001;

   typedef struct packed {
      logic [4:0] ctl;
      logic [8:0] cnt;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [RW-1:0] id_rs_i;
   logic [RW-1:0] id_rt_i;
   logic          id_uses_rt_i;
   logic          ex_mem_read_i;
   logic [RW-1:0] ex_rt_i;
   logic          branch_taken_i;
   logic          mem_req_i;
   logic          mem_ready_i;
   logic          pc_write_o;
   logic          hazard_IF_ID_o;
   logic          flush_IF_ID_o;
   logic          bubble_ID_EX_o;
   logic          freeze_o;
   logic          err_o;
   logic [CW-1:0] stall_cnt_o;
   logic [CW-1:0] flush_cnt_o;

   exp_t  q[$];
   string tq[$];
   int    n_asrt = 0;
   int    n_fail = 0;

   pipeline_hazard_ctrl #(
      .REG_W   (RW),
      .TIMEOUT (8),
      .CNT_W   (CW)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .id_rs_i        (id_rs_i),
      .id_rt_i        (id_rt_i),
      .id_uses_rt_i   (id_uses_rt_i),
      .ex_mem_read_i  (ex_mem_read_i),
      .ex_rt_i        (ex_rt_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ready_i    (mem_ready_i),
      .pc_write_o     (pc_write_o),
      .hazard_IF_ID_o (hazard_IF_ID_o),
      .flush_IF_ID_o  (flush_IF_ID_o),
      .bubble_ID_EX_o (bubble_ID_EX_o),
      .freeze_o       (freeze_o),
      .err_o          (err_o),
      .stall_cnt_o    (stall_cnt_o),
      .flush_cnt_o    (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [8:0] pk(input logic e,
                                     input int s,
                                     input int f);
      return {e, 4'(s), 4'(f)};
   endfunction

   // Queue the expectation, check it at the falling edge, then
   // return just after the next rising edge for the next step.
   task automatic cyc(input string tag,
                      input logic [4:0] ctl,
                      input logic [8:0] cnt);
      exp_t       e;
      string      t;
      logic [4:0] oc;
      logic [8:0] on;
      q.push_back('{ctl: ctl, cnt: cnt});
      tq.push_back(tag);
      @(negedge clk_i);
      e  = q.pop_front();
      t  = tq.pop_front();
      oc = {pc_write_o, hazard_IF_ID_o, flush_IF_ID_o,
            bubble_ID_EX_o, freeze_o};
      on = {err_o, stall_cnt_o, flush_cnt_o};
      n_asrt++;
      assert (oc === e.ctl) else begin
         n_fail++;
         $error("FAIL %s ctl observed=%b expected=%b", t, oc, e.ctl);
      end
      n_asrt++;
      assert (on === e.cnt) else begin
         n_fail++;
         $error("FAIL %s err/stall/flush observed=%h expected=%h",
                t, on, e.cnt);
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i          = 1'b1;
      id_rs_i        = '0;
      id_rt_i        = '0;
      id_uses_rt_i   = 1'b0;
      ex_mem_read_i  = 1'b0;
      ex_rt_i        = '0;
      branch_taken_i = 1'b0;
      mem_req_i      = 1'b0;
      mem_ready_i    = 1'b0;
      #1;

      for (int i = 0; i < 3; i++) cyc("reset", C_INIT, pk(0, 0, 0));
      rst_i = 1'b0;
      cyc("init", C_INIT, pk(0, 0, 0));
      cyc("run0", C_RUN, pk(0, 0, 0));

      ex_mem_read_i = 1'b1; ex_rt_i = 5; id_rs_i = 5;
      cyc("lu_rs", C_LU, pk(0, 0, 0));
      ex_mem_read_i = 1'b0;
      cyc("lu_after", C_RUN, pk(0, 1, 0));
      ex_mem_read_i = 1'b1; ex_rt_i = 0; id_rs_i = 0;
      cyc("lu_r0", C_RUN, pk(0, 1, 0));
      ex_rt_i = 3; id_rt_i = 3; id_uses_rt_i = 1'b0; id_rs_i = 1;
      cyc("lu_rt_unused", C_RUN, pk(0, 1, 0));

      id_uses_rt_i = 1'b1; branch_taken_i = 1'b1;
      cyc("lu_branch", C_LU, pk(0, 1, 0));
      ex_mem_read_i = 1'b0;
      cyc("branch", C_BR, pk(0, 2, 0));
      branch_taken_i = 1'b0;
      cyc("branch_after", C_RUN, pk(0, 2, 1));

      mem_req_i = 1'b1; mem_ready_i = 1'b1;
      cyc("mem_fast", C_RUN, pk(0, 2, 1));
      mem_ready_i = 1'b0; branch_taken_i = 1'b1;
      cyc("mem_entry", C_FRZ, pk(0, 2, 1));
      branch_taken_i = 1'b0;
      for (int k = 1; k <= 3; k++) cyc("mem_wait", C_FRZ, pk(0, 2 + k, 1));
      mem_ready_i = 1'b1;
      cyc("mem_ready", C_FRZ, pk(0, 6, 1));
      mem_req_i = 1'b0; mem_ready_i = 1'b0;
      cyc("mem_done", C_RUN, pk(0, 7, 1));

      rst_i = 1'b1;
      cyc("reset2", C_INIT, pk(0, 0, 0));
      rst_i = 1'b0;
      cyc("init2", C_INIT, pk(0, 0, 0));
      cyc("run2", C_RUN, pk(0, 0, 0));
      mem_req_i = 1'b1;
      cyc("to_entry", C_FRZ, pk(0, 0, 0));
      mem_req_i = 1'b0;
      for (int k = 1; k <= 8; k++) cyc("to_wait", C_FRZ, pk(0, k, 0));
      cyc("to_err", C_RUN, pk(1, 9, 0));
      cyc("to_sticky", C_RUN, pk(1, 9, 0));

      mem_req_i = 1'b1;
      cyc("mid_entry", C_FRZ, pk(1, 9, 0));
      mem_req_i = 1'b0;
      cyc("mid_wait1", C_FRZ, pk(1, 10, 0));
      cyc("mid_wait2", C_FRZ, pk(1, 11, 0));
      rst_i = 1'b1;
      cyc("mid_reset", C_INIT, pk(0, 0, 0));
      rst_i = 1'b0;
      cyc("init3", C_INIT, pk(0, 0, 0));
      cyc("run3", C_RUN, pk(0, 0, 0));

      ex_mem_read_i = 1'b1; ex_rt_i = 7; id_rs_i = 7;
      for (int i = 0; i < 20; i++)
         cyc("sat", C_LU, pk(0, (i > 15) ? 15 : i, 0));
      ex_mem_read_i = 1'b0;
      cyc("sat_hold", C_RUN, pk(0, 15, 0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
